// File: rtl/packet_pkg.sv
// Shared types and helpers for the packet sink: read FSM states, queued packet
// descriptors and the length encoding used on both the sink and read sides.
package packet_pkg;

    localparam logic [7:0] SIZE_256_CODE = 8'h00;

    // Descriptor start pointers are stored at a fixed width so the struct does not
    // depend on the buffer depth; supports buffers up to 32768 bytes.
    localparam int DESC_PTR_W = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic [DESC_PTR_W-1:0] start;
        logic [7:0]            len;
    } desc_t;

    // One extra bit beyond the index distinguishes a full buffer from an empty one.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == SIZE_256_CODE) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/pkt_desc_fifo.sv
// Synchronous FIFO of committed packet descriptors; the head entry is visible
// combinationally so the read FSM can load it without an extra cycle.
module pkt_desc_fifo
    import packet_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   push,
    input  desc_t                  push_desc,
    input  logic                   pop,
    output desc_t                  head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    desc_t           mem [DEPTH];
    logic [AW:0]     wr_idx_reg;
    logic [AW:0]     rd_idx_reg;
    logic            push_ok;
    logic            pop_ok;

    assign count   = wr_idx_reg - rd_idx_reg;
    assign empty   = (wr_idx_reg == rd_idx_reg);
    assign full    = (wr_idx_reg[AW] != rd_idx_reg[AW]) &&
                     (wr_idx_reg[AW-1:0] == rd_idx_reg[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_idx_reg[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_idx_reg[AW-1:0]] <= push_desc;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_idx_reg <= '0;
            rd_idx_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_idx_reg <= wr_idx_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_idx_reg <= rd_idx_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_sink.sv
// Packet sink: buffers body bytes speculatively, commits or rolls back on the size
// strobe, and replays committed packets on a valid/ready port with first/last markers.
module packet_sink
    import packet_pkg::*;
#(
    parameter int BUF_DEPTH = 512,
    parameter int MAX_PKTS  = 8
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [7:0]                sinkData,
    input  logic                      sinkDataValid,
    input  logic [7:0]                sinkDataSize,
    input  logic                      sinkDataSizeValid,
    output logic [7:0]                readData,
    output logic                      readValid,
    input  logic                      readReady,
    output logic                      readFirst,
    output logic                      readLast,
    output logic [7:0]                readLength,
    output logic [$clog2(MAX_PKTS):0] pktCount,
    output logic [7:0]                dropCount
);

    localparam int PTR_W = ptr_width(BUF_DEPTH);
    localparam int AW    = PTR_W - 1;

    logic [7:0]       byte_mem [BUF_DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] cmt_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [8:0]       cnt_reg;
    logic             ovf_reg;
    logic [7:0]       drop_count_reg;

    rd_state_t        state_reg;
    logic [8:0]       rem_reg;
    logic [7:0]       read_length_reg;

    logic             space_ok;
    logic             byte_wr;
    logic [8:0]       cnt_next;
    logic             ovf_next;
    logic [PTR_W-1:0] wr_ptr_next;
    logic             commit;
    logic             drop;

    desc_t            push_desc;
    desc_t            desc_head;
    logic             desc_full;
    logic             desc_empty;
    logic             desc_pop;

    logic             sending;
    logic             accept;
    logic             last_byte;

    // ---------------- write side ----------------
    // rdPtr marks the oldest byte still owned by the reader, so it bounds free space.
    assign space_ok    = (wr_ptr_reg - rd_ptr_reg) < PTR_W'(BUF_DEPTH);
    assign byte_wr     = sinkDataValid && space_ok;
    assign cnt_next    = (sinkDataValid && cnt_reg != '1) ? cnt_reg + 9'd1 : cnt_reg;
    assign ovf_next    = ovf_reg || (sinkDataValid && !space_ok);
    assign wr_ptr_next = wr_ptr_reg + PTR_W'(byte_wr);

    // A byte arriving with the strobe is counted before the length check.
    assign commit = sinkDataSizeValid && !ovf_next && !desc_full &&
                    (cnt_next == len_to_count(sinkDataSize));
    assign drop   = sinkDataSizeValid && !commit;

    assign push_desc = '{start: DESC_PTR_W'(cmt_ptr_reg), len: sinkDataSize};

    always_ff @(posedge CLK) begin
        if (byte_wr) begin
            byte_mem[wr_ptr_reg[AW-1:0]] <= sinkData;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_reg     <= '0;
            cmt_ptr_reg    <= '0;
            cnt_reg        <= '0;
            ovf_reg        <= 1'b0;
            drop_count_reg <= '0;
        end else if (sinkDataSizeValid) begin
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
            if (commit) begin
                wr_ptr_reg  <= wr_ptr_next;
                cmt_ptr_reg <= wr_ptr_next;
            end else begin
                wr_ptr_reg <= cmt_ptr_reg;
                if (drop_count_reg != 8'hFF) begin
                    drop_count_reg <= drop_count_reg + 8'd1;
                end
            end
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            cnt_reg    <= cnt_next;
            ovf_reg    <= ovf_next;
        end
    end

    pkt_desc_fifo #(
        .DEPTH (MAX_PKTS)
    ) u_desc_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (commit),
        .push_desc (push_desc),
        .pop       (desc_pop),
        .head      (desc_head),
        .full      (desc_full),
        .empty     (desc_empty),
        .count     (pktCount)
    );

    // ---------------- read side ----------------
    assign sending   = (state_reg == SEND);
    assign accept    = sending && readReady;
    assign last_byte = (rem_reg == 9'd1);
    assign desc_pop  = accept && last_byte;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg       <= IDLE;
            rd_ptr_reg      <= '0;
            rem_reg         <= '0;
            read_length_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!desc_empty) begin
                        rd_ptr_reg      <= PTR_W'(desc_head.start);
                        rem_reg         <= len_to_count(desc_head.len);
                        read_length_reg <= desc_head.len;
                        state_reg       <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                        rem_reg    <= rem_reg - 9'd1;
                        if (last_byte) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign readValid  = sending;
    assign readData   = sending ? byte_mem[rd_ptr_reg[AW-1:0]] : 8'h00;
    assign readFirst  = sending && (rem_reg == len_to_count(read_length_reg));
    assign readLast   = sending && last_byte;
    assign readLength = read_length_reg;
    assign dropCount  = drop_count_reg;

endmodule

// File: tb/tb_packet_sink.sv
// Directed self-checking bench for packet_sink: each scenario task drives packets
// and compares the read port against hand-computed expectations.
module tb_packet_sink;

    logic       CLK;
    logic       RESET;
    logic [7:0] sinkData;
    logic       sinkDataValid;
    logic [7:0] sinkDataSize;
    logic       sinkDataSizeValid;
    logic [7:0] readData;
    logic       readValid;
    logic       readReady;
    logic       readFirst;
    logic       readLast;
    logic [7:0] readLength;
    logic [3:0] pktCount;
    logic [7:0] dropCount;

    int checks;
    int failures;
    logic [7:0] pkt [$];

    packet_sink #(
        .BUF_DEPTH (512),
        .MAX_PKTS  (8)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .sinkData          (sinkData),
        .sinkDataValid     (sinkDataValid),
        .sinkDataSize      (sinkDataSize),
        .sinkDataSizeValid (sinkDataSizeValid),
        .readData          (readData),
        .readValid         (readValid),
        .readReady         (readReady),
        .readFirst         (readFirst),
        .readLast          (readLast),
        .readLength        (readLength),
        .pktCount          (pktCount),
        .dropCount         (dropCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drives the bytes in pkt on consecutive cycles, then the size strobe.
    // Returns at the falling edge just after the strobe was sampled.
    task automatic send_pkt(input logic [7:0] size);
        foreach (pkt[i]) begin
            @(negedge CLK);
            sinkDataValid = 1'b1;
            sinkData      = pkt[i];
        end
        @(negedge CLK);
        sinkDataValid     = 1'b0;
        sinkData          = 8'h00;
        sinkDataSizeValid = 1'b1;
        sinkDataSize      = size;
        @(negedge CLK);
        sinkDataSizeValid = 1'b0;
        sinkDataSize      = 8'h00;
        $display("tb: sent packet bytes=%0d size=0x%02h", pkt.size(), size);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++; if (readValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", readValid); end
        checks++; if (readFirst !== 1'b0) begin failures++; $display("FAIL reset_first got=%0b exp=0", readFirst); end
        checks++; if (readLast !== 1'b0) begin failures++; $display("FAIL reset_last got=%0b exp=0", readLast); end
        checks++; if (readData !== 8'h00) begin failures++; $display("FAIL reset_data got=%02h exp=00", readData); end
        checks++; if (readLength !== 8'h00) begin failures++; $display("FAIL reset_length got=%02h exp=00", readLength); end
        checks++; if (pktCount !== 4'd0) begin failures++; $display("FAIL reset_pktcount got=%0d exp=0", pktCount); end
        checks++; if (dropCount !== 8'd0) begin failures++; $display("FAIL reset_dropcount got=%0d exp=0", dropCount); end
        RESET = 1'b0;
        $display("tb: reset released");
    endtask

    task automatic test_single();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC;
        readReady = 1'b1;
        pkt = {8'hAA, 8'hBB, 8'hCC};
        send_pkt(8'd3);
        checks++; if (readValid !== 1'b0 || pktCount !== 4'd1) begin
            failures++; $display("FAIL single_commit valid=%0b pktCount=%0d exp valid=0 pktCount=1", readValid, pktCount);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (readValid !== 1'b1 || readData !== exp_b[i] || readFirst !== (i == 0) ||
                readLast !== (i == 2) || readLength !== 8'd3 || pktCount !== 4'd1) begin
                failures++;
                $display("FAIL single_byte%0d valid=%0b data=%02h first=%0b last=%0b len=%0d cnt=%0d exp data=%02h",
                         i, readValid, readData, readFirst, readLast, readLength, pktCount, exp_b[i]);
            end
        end
        @(negedge CLK);
        checks++; if (readValid !== 1'b0 || pktCount !== 4'd0 || dropCount !== 8'd0) begin
            failures++; $display("FAIL single_done valid=%0b pktCount=%0d drop=%0d exp 0/0/0", readValid, pktCount, dropCount);
        end
        $display("tb: single packet done");
    endtask

    task automatic test_mismatch();
        readReady = 1'b1;
        pkt = {8'h11, 8'h12, 8'h13, 8'h14};
        send_pkt(8'd3);
        checks++; if (dropCount !== 8'd1 || pktCount !== 4'd0) begin
            failures++; $display("FAIL mismatch_drop drop=%0d pktCount=%0d exp 1/0", dropCount, pktCount);
        end
        pkt.delete();
        send_pkt(8'd1);
        checks++; if (dropCount !== 8'd2 || pktCount !== 4'd0) begin
            failures++; $display("FAIL empty_drop drop=%0d pktCount=%0d exp 2/0", dropCount, pktCount);
        end
        pkt = {8'h55, 8'h66};
        send_pkt(8'd2);
        checks++; if (readValid !== 1'b0) begin failures++; $display("FAIL mismatch_idle valid=%0b exp=0", readValid); end
        @(negedge CLK);
        checks++; if (readValid !== 1'b1 || readData !== 8'h55 || readFirst !== 1'b1 || readLast !== 1'b0 || readLength !== 8'd2) begin
            failures++; $display("FAIL mismatch_b0 valid=%0b data=%02h first=%0b last=%0b len=%0d exp 1/55/1/0/2",
                                 readValid, readData, readFirst, readLast, readLength);
        end
        @(negedge CLK);
        checks++; if (readValid !== 1'b1 || readData !== 8'h66 || readFirst !== 1'b0 || readLast !== 1'b1) begin
            failures++; $display("FAIL mismatch_b1 valid=%0b data=%02h first=%0b last=%0b exp 1/66/0/1",
                                 readValid, readData, readFirst, readLast);
        end
        @(negedge CLK);
        checks++; if (readValid !== 1'b0 || pktCount !== 4'd0) begin
            failures++; $display("FAIL mismatch_done valid=%0b pktCount=%0d exp 0/0", readValid, pktCount);
        end
        $display("tb: mismatch then good done");
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b [4];
        int idx;
        exp_b[0] = 8'h21; exp_b[1] = 8'h22; exp_b[2] = 8'h23; exp_b[3] = 8'h24;
        readReady = 1'b0;
        pkt = {8'h21, 8'h22, 8'h23, 8'h24};
        send_pkt(8'd4);
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            checks++;
            if (readValid !== 1'b1 || readData !== exp_b[idx] || readFirst !== (idx == 0) || readLast !== (idx == 3)) begin
                failures++;
                $display("FAIL bp_cycle%0d valid=%0b data=%02h first=%0b last=%0b exp data=%02h idx=%0d",
                         c, readValid, readData, readFirst, readLast, exp_b[idx], idx);
            end
            readReady = (c % 2 == 1);
            if (c % 2 == 1) idx++;
        end
        @(negedge CLK);
        checks++; if (readValid !== 1'b0 || pktCount !== 4'd0) begin
            failures++; $display("FAIL bp_done valid=%0b pktCount=%0d exp 0/0", readValid, pktCount);
        end
        $display("tb: backpressure done");
    endtask

    task automatic test_256();
        readReady = 1'b1;
        pkt.delete();
        for (int i = 0; i < 256; i++) pkt.push_back(8'(i));
        send_pkt(8'h00);
        checks++; if (readValid !== 1'b0 || pktCount !== 4'd1 || dropCount !== 8'd2) begin
            failures++; $display("FAIL big_commit valid=%0b pktCount=%0d drop=%0d exp 0/1/2", readValid, pktCount, dropCount);
        end
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            checks++;
            if (readValid !== 1'b1 || readData !== 8'(i) || readFirst !== (i == 0) ||
                readLast !== (i == 255) || readLength !== 8'h00) begin
                failures++;
                $display("FAIL big_byte%0d valid=%0b data=%02h first=%0b last=%0b len=%02h exp data=%02h",
                         i, readValid, readData, readFirst, readLast, readLength, 8'(i));
            end
        end
        @(negedge CLK);
        checks++; if (readValid !== 1'b0 || pktCount !== 4'd0) begin
            failures++; $display("FAIL big_done valid=%0b pktCount=%0d exp 0/0", readValid, pktCount);
        end
        $display("tb: 256-byte packet done");
    endtask

    task automatic test_queue_full();
        do_reset();
        readReady = 1'b0;
        for (int p = 0; p < 9; p++) begin
            pkt = {8'(8'h80 + p)};
            send_pkt(8'd1);
        end
        checks++; if (dropCount !== 8'd1 || pktCount !== 4'd8) begin
            failures++; $display("FAIL qfull_counts drop=%0d pktCount=%0d exp 1/8", dropCount, pktCount);
        end
        checks++; if (readValid !== 1'b1 || readData !== 8'h80 || readFirst !== 1'b1 || readLast !== 1'b1) begin
            failures++; $display("FAIL qfull_head valid=%0b data=%02h first=%0b last=%0b exp 1/80/1/1",
                                 readValid, readData, readFirst, readLast);
        end
        readReady = 1'b1;
        for (int p = 0; p < 8; p++) begin
            if (p != 0) begin
                @(negedge CLK);
                checks++;
                if (readValid !== 1'b1 || readData !== 8'(8'h80 + p) || readFirst !== 1'b1 ||
                    readLast !== 1'b1 || pktCount !== 4'(8 - p)) begin
                    failures++;
                    $display("FAIL qfull_pkt%0d valid=%0b data=%02h first=%0b last=%0b cnt=%0d exp data=%02h cnt=%0d",
                             p, readValid, readData, readFirst, readLast, pktCount, 8'(8'h80 + p), 8 - p);
                end
            end
            @(negedge CLK);
            checks++; if (readValid !== 1'b0) begin
                failures++; $display("FAIL qfull_gap%0d valid=%0b exp=0", p, readValid);
            end
        end
        checks++; if (pktCount !== 4'd0) begin failures++; $display("FAIL qfull_done pktCount=%0d exp=0", pktCount); end
        $display("tb: queue full done");
    endtask

    task automatic test_reset_mid();
        readReady = 1'b1;
        @(negedge CLK); sinkDataValid = 1'b1; sinkData = 8'hA1;
        @(negedge CLK); sinkData = 8'hA2;
        @(negedge CLK); sinkDataValid = 1'b0; sinkData = 8'h00; RESET = 1'b1;
        @(negedge CLK); RESET = 1'b0;
        checks++; if (readValid !== 1'b0 || readFirst !== 1'b0 || readLast !== 1'b0 || readData !== 8'h00 ||
                      readLength !== 8'h00 || pktCount !== 4'd0 || dropCount !== 8'd0) begin
            failures++; $display("FAIL midreset_outputs valid=%0b first=%0b last=%0b data=%02h len=%0d cnt=%0d drop=%0d exp all 0",
                                 readValid, readFirst, readLast, readData, readLength, pktCount, dropCount);
        end
        pkt = {8'hB1, 8'hB2, 8'hB3};
        send_pkt(8'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (readValid !== 1'b1 || readData !== 8'(8'hB1 + i) || readFirst !== (i == 0) ||
                readLast !== (i == 2) || readLength !== 8'd3) begin
                failures++;
                $display("FAIL midreset_byte%0d valid=%0b data=%02h first=%0b last=%0b len=%0d exp data=%02h",
                         i, readValid, readData, readFirst, readLast, readLength, 8'(8'hB1 + i));
            end
        end
        @(negedge CLK);
        checks++; if (readValid !== 1'b0 || pktCount !== 4'd0 || dropCount !== 8'd0) begin
            failures++; $display("FAIL midreset_done valid=%0b pktCount=%0d drop=%0d exp 0/0/0", readValid, pktCount, dropCount);
        end
        $display("tb: reset mid-packet done");
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        RESET             = 1'b1;
        sinkData          = 8'h00;
        sinkDataValid     = 1'b0;
        sinkDataSize      = 8'h00;
        sinkDataSizeValid = 1'b0;
        readReady         = 1'b0;
        test_reset();
        test_single();
        test_mismatch();
        test_backpressure();
        test_256();
        test_queue_full();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
